// File: rtl/ms_timer_pkg.sv
// Shared control encodings and prescaler divide helpers for ms_timer_counter.
package ms_timer_pkg;

  localparam logic [1:0] CTRL_CLEAR = 2'b00;
  localparam logic [1:0] CTRL_HOLD  = 2'b01;
  localparam logic [1:0] CTRL_RUN   = 2'b10;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Elaboration guard: the tick period must be an exact, non-trivial number of clocks.
  function automatic bit div_ok(input int unsigned clk_hz, input int unsigned tick_hz);
    return (tick_hz != 0) && (clk_hz % tick_hz == 0) && (clk_hz / tick_hz >= 2);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk_50M by DIV while enabled; wrap flags the last prescaler cycle and tick is its
// registered one-cycle echo.
module tick_prescaler #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic wrap,
  output logic tick
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] Last = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  always_comb begin
    pre_d  = pre_q;
    tick_d = 1'b0;
    wrap   = en && (pre_q == Last);
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d  = wrap ? '0 : pre_q + 1'b1;
      tick_d = wrap;
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/ms_timer_counter.sv
// Saturating elapsed-tick counter with lap capture. Define MS_TIMER_BCD_OUT_EN to add a BCD
// mirror of the count on bcd_out.
module ms_timer_counter
  import ms_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned CNT_W   = 10,
  parameter int unsigned CNT_MAX = 999
`ifdef MS_TIMER_BCD_OUT_EN
  ,
  parameter int unsigned BCD_DIGITS = 3
`endif
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic [1:0]       ctrl_flag,
  input  logic             capture,
  output logic [CNT_W-1:0] cnt_out,
  output logic [CNT_W-1:0] cap_out,
  output logic             cap_valid,
  output logic             sat,
  output logic             tick
`ifdef MS_TIMER_BCD_OUT_EN
  ,
  output logic [4*BCD_DIGITS-1:0] bcd_out
`endif
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX);

  if (!div_ok(CLK_HZ, TICK_HZ)) begin : g_bad_div
    $error("ms_timer_counter: CLK_HZ/TICK_HZ must divide exactly with DIV >= 2");
  end

  logic clr, run, wrap, inc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cap_q, cap_d;
  logic             capv_q, capv_d, sat_q, sat_d;

  assign clr = (ctrl_flag == CTRL_CLEAR);
  assign run = (ctrl_flag == CTRL_RUN);
  assign inc = wrap && (cnt_q < CntMax);

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk_50M(clk_50M),
    .rst    (rst),
    .clr    (clr),
    .en     (run),
    .wrap   (wrap),
    .tick   (tick)
  );

  always_comb begin
    cnt_d  = cnt_q;
    cap_d  = cap_q;
    capv_d = capv_q;
    if (clr) begin
      cnt_d  = '0;
      cap_d  = '0;
      capv_d = 1'b0;
    end else begin
      // Capture sees the pre-edge count, even when a tick lands on the same edge.
      if (capture) begin
        cap_d  = cnt_q;
        capv_d = 1'b1;
      end
      if (inc) cnt_d = cnt_q + 1'b1;
    end
    sat_d = (cnt_d == CntMax);
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      cap_q  <= '0;
      capv_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cap_q  <= cap_d;
      capv_q <= capv_d;
      sat_q  <= sat_d;
    end
  end

  assign cnt_out   = cnt_q;
  assign cap_out   = cap_q;
  assign cap_valid = capv_q;
  assign sat       = sat_q;

`ifdef MS_TIMER_BCD_OUT_EN
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;
  logic                    carry;
  logic [3:0]              dig;

  // Ripple a +1 through the digits; follows inc so it freezes with the binary count.
  always_comb begin
    bcd_d = bcd_q;
    carry = 1'b0;
    dig   = '0;
    if (clr) begin
      bcd_d = '0;
    end else if (inc) begin
      carry = 1'b1;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
        dig = bcd_q[4*i +: 4];
        if (carry) begin
          if (dig == 4'd9) begin
            bcd_d[4*i +: 4] = 4'd0;
          end else begin
            bcd_d[4*i +: 4] = dig + 4'd1;
            carry           = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) bcd_q <= '0;
    else     bcd_q <= bcd_d;
  end

  assign bcd_out = bcd_q;
`endif

endmodule

// File: tb/tb_ms_timer_counter.sv
// Scoreboard bench for ms_timer_counter: directed scenarios then randomized control/capture,
// checked against an elapsed-run-cycle model.
`timescale 1ns / 1ps
module tb_ms_timer_counter;

  localparam int unsigned DIV     = 10;
  localparam int unsigned CNT_MAX = 5;

  logic       clk_50M = 1'b0;
  logic       rst     = 1'b1;
  logic [1:0] ctrl_flag = 2'b00;
  logic       capture = 1'b0;
  logic [3:0] cnt_out, cap_out;
  logic       cap_valid, sat, tick;

  always #5 clk_50M = ~clk_50M;

  ms_timer_counter #(
    .CLK_HZ (10),
    .TICK_HZ(1),
    .CNT_W  (4),
    .CNT_MAX(CNT_MAX)
  ) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .ctrl_flag(ctrl_flag),
    .capture  (capture),
    .cnt_out  (cnt_out),
    .cap_out  (cap_out),
    .cap_valid(cap_valid),
    .sat      (sat),
    .tick     (tick)
  );

`ifdef MS_TIMER_BCD_OUT_EN
  logic [1:0]  ctrl2 = 2'b00;
  logic [9:0]  cnt2, cap2;
  logic        capv2, sat2, tick2;
  logic [11:0] bcd2;

  ms_timer_counter #(
    .CLK_HZ (2),
    .TICK_HZ(1)
  ) dut_bcd (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .ctrl_flag(ctrl2),
    .capture  (1'b0),
    .cnt_out  (cnt2),
    .cap_out  (cap2),
    .cap_valid(capv2),
    .sat      (sat2),
    .tick     (tick2),
    .bcd_out  (bcd2)
  );
`endif

  typedef struct {
    int unsigned cnt;
    int unsigned cap;
    int unsigned capv;
    int unsigned sat;
    int unsigned tick;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: run cycles accumulated since the last clear/reset.
  int unsigned m_run  = 0;
  int unsigned m_cap  = 0;
  int unsigned m_capv = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int unsigned m_count();
    int unsigned c;
    c = m_run / DIV;
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  // Drive one cycle's inputs and push the model's view of the outputs after the next edge.
  task automatic cycle(input logic [1:0] c, input bit cp, input bit r);
    exp_t e;
    @(negedge clk_50M);
    ctrl_flag = c;
    capture   = cp;
    rst       = r;
    e.tick    = 0;
    if (r || c == 2'b00) begin
      m_run  = 0;
      m_cap  = 0;
      m_capv = 0;
    end else begin
      if (cp) begin
        m_cap  = m_count();
        m_capv = 1;
      end
      if (c == 2'b10) begin
        m_run++;
        e.tick = (m_run % DIV == 0) ? 1 : 0;
      end
    end
    e.cnt  = m_count();
    e.cap  = m_cap;
    e.capv = m_capv;
    e.sat  = (m_count() == CNT_MAX) ? 1 : 0;
    sb_q.push_back(e);
  endtask

  task automatic run_n(input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) cycle(c, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_50M);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("cnt_out", cnt_out, e.cnt);
        chk("cap_out", cap_out, e.cap);
        chk("cap_valid", cap_valid, e.capv);
        chk("sat", sat, e.sat);
        chk("tick", tick, e.tick);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int unsigned rv;
    logic [1:0]  c;
    // Reset state
    cycle(2'b00, 1'b0, 1'b1);
    cycle(2'b10, 1'b1, 1'b1);
    cycle(2'b00, 1'b0, 1'b0);

    // First tick latency, saturation, ticks while saturated
    run_n(2'b10, 10);
    run_n(2'b10, 60);
    run_n(2'b10, 20);

    // Asynchronous reset mid-run at count 3
    cycle(2'b00, 1'b0, 1'b0);
    run_n(2'b10, 30);
    cycle(2'b10, 1'b1, 1'b0);
    @(posedge clk_50M);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", cnt_out, 0);
    chk("async_rst_cap", cap_out, 0);
    chk("async_rst_capv", cap_valid, 0);
    chk("async_rst_tick", tick, 0);
    m_run = 0; m_cap = 0; m_capv = 0;
    cycle(2'b10, 1'b0, 1'b1);

    // Hold resumes the partial period
    cycle(2'b00, 1'b0, 1'b0);
    run_n(2'b10, 14);
    run_n(2'b01, 4);
    run_n(2'b11, 3);
    run_n(2'b10, 6);

    // Capture on a tick cycle, then capture during hold
    run_n(2'b10, 9);
    cycle(2'b10, 1'b1, 1'b0);
    run_n(2'b01, 2);
    cycle(2'b11, 1'b1, 1'b0);

    // Capture and clear together: clear wins
    run_n(2'b10, 10);
    cycle(2'b00, 1'b1, 1'b0);
    run_n(2'b10, 3);

    // Randomized control and capture
    for (int i = 0; i < 1500; i++) begin
      rv = $urandom_range(0, 15);
      c  = (rv == 0) ? 2'b00 : (rv < 3) ? 2'b01 : (rv == 3) ? 2'b11 : 2'b10;
      cycle(c, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
    end

    @(negedge clk_50M);
    @(negedge clk_50M);
    chk("sb_drain", sb_q.size(), 0);

`ifdef MS_TIMER_BCD_OUT_EN
    begin : bcd_test
      int unsigned v, exp_bcd;
      @(negedge clk_50M);
      rst   = 1'b0;
      ctrl2 = 2'b10;
      for (int k = 1; k <= 2010; k++) begin
        @(negedge clk_50M);
        v       = (k / 2 > 999) ? 999 : k / 2;
        exp_bcd = ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
        if (v == 9 || v == 10 || v == 99 || v == 100 || v == 999) begin
          chk("bcd_cnt", cnt2, v);
          chk("bcd_out", bcd2, exp_bcd);
        end
      end
      ctrl2 = 2'b00;
      @(negedge clk_50M);
      chk("bcd_clear", bcd2, 0);
      chk("bcd_clear_cnt", cnt2, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
